// File: rtl/bram1_scan_ctrl_l7.sv
// bram1_scan_ctrl_l7: layer-7 BRAM1 address sequencer.
// Walks LD0/LD1/RD/SH/OUT raster phases, then drains the x/y delay line.
module bram1_scan_ctrl_l7 #(
  parameter int DIM = 16,
  parameter int DLY = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       en,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic [4:0] x_Reg5,
  output logic [4:0] y_Reg5,
  output logic [2:0] u,
  output logic [1:0] k,
  output logic [1:0] z,
  output logic       L_zero,
  output logic       valid,
  output logic       busy,
  output logic       done
);
  localparam logic [4:0] LAST = 5'(DIM - 1);
  localparam int DW = $clog2(DLY + 1);
  localparam logic [DW-1:0] DEND = DW'(DLY);

  typedef enum logic [2:0] {
    IDLE, LD0, LD1, RD, SH, OUT, DRAIN
  } st_t;

  st_t st, st_n;
  logic [4:0] x_n, y_n, xa, ya;
  logic [1:0] k_n, z_n;
  logic [DW-1:0] dc, dc_n;
  logic last, clr;
  logic [9:0] sr [DLY];

  always_comb begin
    last = (x == LAST) && (y == LAST);
    ya = (y == LAST) ? 5'd0 : y + 5'd1;
    xa = x;
    if (y == LAST)
      xa = (x == LAST) ? 5'd0 : x + 5'd1;
  end

  always_comb begin
    st_n = st;
    x_n = x;
    y_n = y;
    k_n = k;
    z_n = z;
    dc_n = dc;
    clr = 1'b0;
    if (en) begin
      unique case (st)
        IDLE: if (start) begin
          st_n = LD0;
          x_n = '0;
          y_n = '0;
          k_n = '0;
          z_n = '0;
          dc_n = '0;
          clr = 1'b1;
        end
        LD0, LD1, RD: begin
          x_n = xa;
          y_n = ya;
          if (last) begin
            if (st == LD0) st_n = LD1;
            else if (st == LD1) st_n = RD;
            else begin
              st_n = SH;
              k_n = 2'd1;
            end
          end
        end
        SH: begin
          if (k == 2'd3) begin
            x_n = xa;
            y_n = ya;
            k_n = 2'd1;
            if (last) begin
              st_n = OUT;
              k_n = 2'd0;
              z_n = 2'd0;
            end
          end else begin
            k_n = k + 2'd1;
          end
        end
        OUT: begin
          if (z == 2'd2) begin
            if (last) begin
              st_n = DRAIN;
              dc_n = '0;
            end else begin
              x_n = xa;
              y_n = ya;
              z_n = 2'd0;
            end
          end else begin
            z_n = z + 2'd1;
          end
        end
        DRAIN: begin
          // final count is the done cycle, still outside IDLE
          if (dc == DEND) begin
            st_n = IDLE;
            x_n = '0;
            y_n = '0;
            z_n = '0;
            dc_n = '0;
          end else begin
            dc_n = dc + 1'b1;
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else st <= st_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      k <= '0;
      z <= '0;
      dc <= '0;
    end else begin
      x <= x_n;
      y <= y_n;
      k <= k_n;
      z <= z_n;
      dc <= dc_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) sr[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DLY; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= {x, y};
      for (int i = 1; i < DLY; i++) sr[i] <= sr[i-1];
    end
  end

  assign x_Reg5 = sr[DLY-1][9:5];
  assign y_Reg5 = sr[DLY-1][4:0];

  always_comb begin
    u = 3'd0;
    L_zero = 1'b0;
    valid = 1'b0;
    unique case (st)
      IDLE: u = 3'd0;
      LD0: valid = en;
      LD1: begin
        L_zero = 1'b1;
        valid = en;
      end
      RD: begin
        u = 3'd2;
        valid = en;
      end
      SH: begin
        u = 3'd3;
        valid = en;
      end
      OUT: begin
        u = 3'd4;
        valid = en;
      end
      DRAIN: u = 3'd4;
      default: u = 3'd0;
    endcase
    done = en && (st == DRAIN) && (dc == DEND);
    busy = (st != IDLE) && !done;
  end
endmodule

// File: tb/tb_bram1_scan_ctrl_l7.sv
// tb_bram1_scan_ctrl_l7: directed bench for the layer-7 scan sequencer.
// Three instances cover DIM=16, DIM=4 and DIM=1.
module tb_bram1_scan_ctrl_l7;
  logic clk = 1'b0;
  logic rst_n, en;
  logic start_a, start_b, start_c;
  always #5 clk = ~clk;

  logic [4:0] x_a, y_a, xr_a, yr_a;
  logic [4:0] x_b, y_b, xr_b, yr_b;
  logic [4:0] x_c, y_c, xr_c, yr_c;
  logic [2:0] u_a, u_b, u_c;
  logic [1:0] k_a, k_b, k_c, z_a, z_b, z_c;
  logic lz_a, lz_b, lz_c, v_a, v_b, v_c;
  logic b_a, b_b, b_c, d_a, d_b, d_c;

  bram1_scan_ctrl_l7 #(.DIM(16), .DLY(5)) u_a16 (
    .clk(clk), .rst_n(rst_n), .start(start_a), .en(en),
    .x(x_a), .y(y_a), .x_Reg5(xr_a), .y_Reg5(yr_a),
    .u(u_a), .k(k_a), .z(z_a), .L_zero(lz_a),
    .valid(v_a), .busy(b_a), .done(d_a));

  bram1_scan_ctrl_l7 #(.DIM(4), .DLY(5)) u_b4 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .en(en),
    .x(x_b), .y(y_b), .x_Reg5(xr_b), .y_Reg5(yr_b),
    .u(u_b), .k(k_b), .z(z_b), .L_zero(lz_b),
    .valid(v_b), .busy(b_b), .done(d_b));

  bram1_scan_ctrl_l7 #(.DIM(1), .DLY(5)) u_c1 (
    .clk(clk), .rst_n(rst_n), .start(start_c), .en(en),
    .x(x_c), .y(y_c), .x_Reg5(xr_c), .y_Reg5(yr_c),
    .u(u_c), .k(k_c), .z(z_c), .L_zero(lz_c),
    .valid(v_c), .busy(b_c), .done(d_c));

  typedef struct {
    int cyc;
    logic [30:0] exp;
  } row_t;

  int checks = 0;
  int failures = 0;
  row_t tab[$];

  function automatic logic [30:0] pk(
    input int x, input int y, input int xr, input int yr,
    input int u, input int k, input int z,
    input int lz, input int v, input int b, input int d);
    return {5'(x), 5'(y), 5'(xr), 5'(yr), 3'(u), 2'(k), 2'(z),
            1'(lz), 1'(v), 1'(b), 1'(d)};
  endfunction

  function automatic logic [30:0] pa();
    return {x_a, y_a, xr_a, yr_a, u_a, k_a, z_a, lz_a, v_a, b_a, d_a};
  endfunction

  function automatic logic [30:0] pb();
    return {x_b, y_b, xr_b, yr_b, u_b, k_b, z_b, lz_b, v_b, b_b, d_b};
  endfunction

  function automatic logic [30:0] pc();
    return {x_c, y_c, xr_c, yr_c, u_c, k_c, z_c, lz_c, v_c, b_c, d_c};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int c, input logic [30:0] e);
    row_t r;
    r.cyc = c;
    r.exp = e;
    tab.push_back(r);
  endtask

  int ti, ehc, errs_v, errs_s, ndone, dcyc, nld, nsh, nout, ndr, s, idx;
  int got;

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    #2;
    chk("reset_a", 32'(pa()), 32'd0);
    chk("reset_b", 32'(pb()), 32'd0);
    chk("reset_c", 32'(pc()), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    //        c     x  y  xr yr u k z lz v b d
    add(0,    pk(0, 0, 0, 0, 0,0,0, 0,1,1,0));
    add(1,    pk(0, 1, 0, 0, 0,0,0, 0,1,1,0));
    add(5,    pk(0, 5, 0, 0, 0,0,0, 0,1,1,0));
    add(16,   pk(1, 0, 0,11, 0,0,0, 0,1,1,0));
    add(21,   pk(1, 5, 1, 0, 0,0,0, 0,1,1,0));
    add(255,  pk(15,15,15,10, 0,0,0, 0,1,1,0));
    add(256,  pk(0, 0,15,11, 0,0,0, 1,1,1,0));
    add(260,  pk(0, 4,15,15, 0,0,0, 1,1,1,0));
    add(261,  pk(0, 5, 0, 0, 0,0,0, 1,1,1,0));
    add(512,  pk(0, 0,15,11, 2,0,0, 0,1,1,0));
    add(767,  pk(15,15,15,10, 2,0,0, 0,1,1,0));
    add(768,  pk(0, 0,15,11, 3,1,0, 0,1,1,0));
    add(769,  pk(0, 0,15,12, 3,2,0, 0,1,1,0));
    add(770,  pk(0, 0,15,13, 3,3,0, 0,1,1,0));
    add(771,  pk(0, 1,15,14, 3,1,0, 0,1,1,0));
    add(772,  pk(0, 1,15,15, 3,2,0, 0,1,1,0));
    add(773,  pk(0, 1, 0, 0, 3,3,0, 0,1,1,0));
    add(776,  pk(0, 2, 0, 1, 3,3,0, 0,1,1,0));
    add(1535, pk(15,15,15,14, 3,3,0, 0,1,1,0));
    add(1536, pk(0, 0,15,14, 4,0,0, 0,1,1,0));
    add(1538, pk(0, 0,15,15, 4,0,2, 0,1,1,0));
    add(1539, pk(0, 1,15,15, 4,0,0, 0,1,1,0));
    add(1541, pk(0, 1, 0, 0, 4,0,2, 0,1,1,0));
    add(2303, pk(15,15,15,14, 4,0,2, 0,1,1,0));
    add(2304, pk(15,15,15,14, 4,0,2, 0,0,1,0));
    add(2308, pk(15,15,15,15, 4,0,2, 0,0,1,0));
    add(2309, pk(15,15,15,15, 4,0,2, 0,0,0,1));
    add(2310, pk(0, 0,15,15, 0,0,0, 0,0,0,0));
    add(2320, pk(0, 0, 0, 0, 0,0,0, 0,0,0,0));

    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    ti = 0;
    for (int c = 0; c <= 2320; c++) begin
      #2;
      while (ti < tab.size() && tab[ti].cyc == c) begin
        chk($sformatf("d16_cyc%0d", c), 32'(pa()), 32'(tab[ti].exp));
        ti++;
      end
      tick();
    end

    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    nout = 0;
    dcyc = -1;
    for (int c = 0; c <= 160; c++) begin
      #2;
      if (c == 5)
        chk("d4_xr_c5", 32'(pb()), 32'(pk(1,1,0,0,0,0,0,0,1,1,0)));
      if (c == 6)
        chk("d4_xr_c6", 32'(pb()), 32'(pk(1,2,0,1,0,0,0,0,1,1,0)));
      if (c == 48) chk("d4_sh0", {x_b, y_b, 4'(k_b), 3'(u_b)},
                       {5'd0, 5'd0, 4'd1, 3'd3});
      if (c == 49) chk("d4_sh1", {x_b, y_b, 4'(k_b), 3'(u_b)},
                       {5'd0, 5'd0, 4'd2, 3'd3});
      if (c == 50) chk("d4_sh2", {x_b, y_b, 4'(k_b), 3'(u_b)},
                       {5'd0, 5'd0, 4'd3, 3'd3});
      if (c == 51) chk("d4_sh3", {x_b, y_b, 4'(k_b), 3'(u_b)},
                       {5'd0, 5'd1, 4'd1, 3'd3});
      if (v_b && u_b == 3'd4) nout++;
      if (d_b && dcyc < 0) dcyc = c;
      tick();
    end
    chk("d4_out_cycles", 32'(nout), 32'd48);
    chk("d4_done_cycle", 32'(dcyc), 32'd149);

    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    ehc = 0;
    errs_v = 0;
    errs_s = 0;
    got = 0;
    for (int c = 0; c < 8000 && got == 0; c++) begin
      if (ehc >= 768 && ehc < 1536) en = 1'($urandom_range(0, 1));
      else en = 1'b1;
      #2;
      if (!en) begin
        if (v_a) errs_v++;
      end else if (d_a) begin
        got = 1;
      end else begin
        if (ehc >= 768 && ehc < 1536) begin
          s = ehc - 768;
          idx = s / 3;
          if (x_a != 5'(idx / 16) || y_a != 5'(idx % 16) ||
              k_a != 2'(s % 3 + 1) || u_a != 3'd3 || !v_a) begin
            if (errs_s == 0)
              $display("FAIL en_sh_step s=%0d got x=%0d y=%0d k=%0d",
                       s, x_a, y_a, k_a);
            errs_s++;
          end
        end
        ehc++;
      end
      if (got == 0) tick();
    end
    en = 1'b1;
    chk("en_done_seen", 32'(got), 32'd1);
    chk("en_high_cycles", 32'(ehc), 32'd2309);
    chk("en0_valid_low", 32'(errs_v), 32'd0);
    chk("en_sh_sequence", 32'(errs_s), 32'd0);
    tick();

    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    nld = 0;
    nsh = 0;
    nout = 0;
    ndr = 0;
    ndone = 0;
    dcyc = -1;
    for (int c = 0; c <= 32; c++) begin
      start_c = (c == 3 || c == 7 || c == 14 || c == 15);
      #2;
      if (c <= 14) begin
        if (v_c && u_c <= 3'd2) nld++;
        if (v_c && u_c == 3'd3) nsh++;
        if (v_c && u_c == 3'd4) nout++;
        if (b_c && !v_c) ndr++;
      end
      if (d_c && c <= 29) begin
        ndone++;
        if (dcyc < 0) dcyc = c;
      end
      if (c == 15)
        chk("d1_no_restart", {31'(b_c), 1'(v_c)}, 32'd0);
      if (c == 16)
        chk("d1_restart", 32'(pc()), 32'(pk(0,0,0,0,0,0,0,0,1,1,0)));
      if (c == 30)
        chk("d1_second_done", 32'(d_c), 32'd1);
      tick();
    end
    start_c = 1'b0;
    chk("d1_ld_rd", 32'(nld), 32'd3);
    chk("d1_sh", 32'(nsh), 32'd3);
    chk("d1_out", 32'(nout), 32'd3);
    chk("d1_drain", 32'(ndr), 32'd5);
    chk("d1_done_cycle", 32'(dcyc), 32'd14);
    chk("d1_single_done", 32'(ndone), 32'd1);

    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 1600; c++) tick();
    #2;
    chk("abort_in_out", 32'(u_a), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("abort_zero", 32'(pa()), 32'd0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (d_a || b_a) ndone++;
      tick();
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    ndone = 0;
    dcyc = -1;
    for (int c = 0; c <= 2315; c++) begin
      #2;
      if (c == 0)
        chk("clean_first", 32'(pa()), 32'(pk(0,0,0,0,0,0,0,0,1,1,0)));
      if (c == 1536)
        chk("clean_out", 32'(pa()), 32'(pk(0,0,15,14,4,0,0,0,1,1,0)));
      if (d_a) begin
        ndone++;
        if (dcyc < 0) dcyc = c;
      end
      tick();
    end
    chk("clean_done_cycle", 32'(dcyc), 32'd2309);
    chk("clean_single_done", 32'(ndone), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram1_scan_ctrl_l7.md
# bram1_scan_ctrl_l7

Sequencer for the layer-7 BRAM1 address path. On a start pulse it walks the layer through its five access phases: lower-half load, upper-half load, registered read, k-shifted read and z-split output. For each phase it emits the scan coordinates x/y, the phase code u, the sub-indices k/z, the L_zero half select and the 5-cycle-delayed coordinates x_Reg5/y_Reg5. These are the exact inputs the layer-7 BRAM1 address decoder consumes. The block sits between the layer-7 top-level FSM (start/done) and the address decoder.

## Interface
Parameters:
- DIM, 16, edge length of the feature map; legal 1..16. Coordinates run 0..DIM-1.
- DLY, 5, depth of the x_Reg5/y_Reg5 delay line; fixed at 5 for layer 7.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  one-cycle request to begin a layer pass; honoured only in IDLE.
- en  in  1  advance enable; 0 freezes every counter, the state and the delay line.
- x, y  out  5  current scan coordinates.
- x_Reg5, y_Reg5  out  5  x/y as issued DLY advancing cycles earlier.
- u  out  3  phase code: 0 load, 2 registered read, 3 shifted read, 4 output.
- k  out  2  shift index, 1..3 during u=3, else 0.
- z  out  2  output split index, 0..2 during u=4, else 0.
- L_zero  out  1  1 during the upper-half load pass only.
- valid  out  1  current coordinate set is a real access.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at pass completion.

## Operation
- States: IDLE, LD0, LD1, RD, SH, OUT, DRAIN.
- IDLE → LD0 when start=1.
- Any other state ignores start.
- Raster order in all scan states:
  - y is the fastest index, 0..DIM-1; on y wrap, x increments.
  - Both indices are 5-bit; a wrap returns them to 0.
- LD0 (u=0, L_zero=0): one cycle per (x,y).
  - After (DIM-1,DIM-1), go to LD1.
- LD1 (u=0, L_zero=1): same scan, then go to RD.
- RD (u=2): same scan, then go to SH.
- SH (u=3): each (x,y) is held for 3 cycles with k=1,2,3.
  - The coordinate advances when k=3.
  - After (DIM-1,DIM-1,k=3), go to OUT.
- OUT (u=4): each (x,y) is held for 3 cycles with z=0,1,2.
  - After the final z=2, go to DRAIN.
- DRAIN (u=4, z=2 held, x/y held at last value, valid=0): lasts DLY cycles, so the delay line empties.
  - Then go to IDLE with done=1 for exactly that one transition cycle.
- Delay line: a DLY-deep shift of {x,y}, loaded every cycle en=1.
  - x_Reg5/y_Reg5 are its output.
  - It clears to 0 on reset and on entering LD0.
- valid=1 in LD0, LD1, RD, SH and OUT whenever en=1; valid=0 in IDLE and DRAIN.
- en=0: all outputs hold their values, except that valid drops to 0. No counter, state or delay stage moves.

## Timing
- Reset values: all outputs 0, state IDLE.
- An asserted rst_n=0 mid-pass aborts at once: outputs go to 0 and no done is issued.
- Latency: start sampled at edge N; LD0 with (0,0), valid=1 appears after edge N (cycle N+1).
- Cycle counts with en held at 1, measured from the first LD0 cycle to done:
  - 3·DIM² cycles for LD0+LD1+RD;
  - 6·DIM² cycles for SH+OUT;
  - DLY cycles for DRAIN.
  - For DIM=16 the total is 2309 cycles.
- Phase transitions take no bubble: the first cycle of the next phase follows the last cycle of the previous one directly, with x=y=0, k=1 (SH) or z=0 (OUT).
- done coincides with busy falling. A start asserted in that same cycle is ignored, because the block is not yet in IDLE. A start one cycle later is accepted.
- x_Reg5 equals the x issued exactly DLY en-high cycles earlier, regardless of phase boundaries.

## Test plan
- Reset, then start with DIM=16 and en=1: LD0 begins at (0,0), u=0, L_zero=0. LD1 begins at cycle 256 with L_zero=1. u=2 at 512, u=3 with k=1 at 768, u=4 with z=0 at 1536. done=1 at cycle 2309, busy=0 after.
- DIM=4: in SH, the sequence (0,0,k1),(0,0,k2),(0,0,k3),(0,1,k1) holds. OUT runs 48 cycles. x_Reg5,y_Reg5 = (0,0) at the 6th LD0 cycle.
- Toggle en 0/1 randomly during SH: the k/x/y sequence is identical to the en=1 run. valid=0 on every en=0 cycle. Total en-high cycles = 2309.
- Start pulses while busy, plus a start coincident with done: no restart, and a single done. Start one cycle after done begins a new pass.
- rst_n low in the middle of OUT: next cycle all outputs are 0, no done pulse. A subsequent start runs a full, clean pass.
- DIM=1: 3 LD/RD cycles, 6 SH/OUT cycles, 5 DRAIN cycles, then done at cycle 14.
